inv_dir_arbiter: RTL and testbench
==================================

# inv_dir_arbiter

Round-robin scheduler that shares one Fixed3 inverse-direction unit (the `Fixed3_Inv_V2` datapath) among `NUM_REQ` ray-generator clients. Primary and shadowing ray generators each need `InvDir` once per ray. A single arbitrated divider replaces one divider per generator. The block sits between the generators and the inverse unit. It latches the granted client's direction vector, pulses the unit's strobe, waits for the result, and returns the result to the requester with a one-cycle done pulse.

## Interface
- `NUM_REQ`, default 4: number of requesting clients, range 2..8.
- `TIMEOUT_CYCLES`, default 64: watchdog limit in cycles, used only when `INV_ARB_TIMEOUT_EN` is defined; range 2..255.
- `clk`  in  1: single clock; all state updates on its rising edge.
- `resetn`  in  1: asynchronous, active-low reset.
- `req`  in  NUM_REQ: per-client request level. The client holds it high until its `done` bit pulses.
- `req_v`  in  NUM_REQ x Fixed3: per-client direction vector, sampled only at grant.
- `done`  out  NUM_REQ: one-hot, one-cycle pulse marking completion for the granted client.
- `error`  out  NUM_REQ: one-hot, one-cycle pulse coincident with `done` when a watchdog timeout occurred.
- `result`  out  Fixed3: inverse vector; valid while `done` is high, held until the next completion.
- `busy`  out  1: high in every state except IDLE.
- `inv_strobe`  out  1: start pulse to the inverse unit.
- `inv_v`  out  Fixed3: latched operand to the inverse unit, stable from ISSUE through RESPOND.
- `inv_valid`  in  1: result-ready flag from the inverse unit.
- `inv_ov`  in  Fixed3: result from the inverse unit.

## Operation
- States: IDLE, ISSUE, WAIT, RESPOND. There is exactly one outstanding operation at a time.
- IDLE:
  - If any `req` bit is high, select the first set bit searching upward from `last_grant+1`, modulo NUM_REQ.
  - Register the selection into `grant_id`, latch `req_v[grant_id]` into `inv_v`, and move to ISSUE.
  - If no `req` bit is high, stay in IDLE.
- ISSUE: drive `inv_strobe`=1 for this single cycle, clear the watchdog counter, and move to WAIT.
- WAIT:
  - `inv_strobe` is 0.
  - On `inv_valid`=1, latch `inv_ov` into `result` and move to RESPOND.
  - `inv_valid` is ignored in every state other than WAIT.
- RESPOND:
  - `done[grant_id]`=1 for this one cycle; `last_grant` is set to `grant_id`.
  - Move to IDLE.
- Fairness: after a client is served, every other pending client is served before it is granted again.
- Changes to `req` or `req_v` after grant have no effect on the operation in flight.
- A `req` bit that falls before grant is simply not selected.
- A client that keeps `req` high after its `done` is treated as a new request.
- Reset values:
  - State IDLE; `done`, `error`, `inv_strobe` and `busy` all 0.
  - `result` and `inv_v` are 0; `grant_id` is 0.
  - `last_grant` is NUM_REQ-1, so client 0 has top priority after reset.
- Reset asserted mid-operation aborts the operation with no `done` pulse. A late `inv_valid` arriving afterwards is ignored because the block is in IDLE.

## Timing
- Request to strobe: `req` seen at IDLE in cycle N, ISSUE strobe in cycle N+1.
- Result to done: `inv_valid` in WAIT at cycle M, `done` in cycle M+1.
- Total latency is unit latency + 3 cycles. The minimum is 4 cycles when `inv_valid` arrives in the first WAIT cycle.
- Back-to-back throughput: IDLE lasts one cycle between operations, so the minimum spacing between grants is unit latency + 3 cycles.
- Simultaneous `done` for one client and `req` from another: the new request is arbitrated in the following IDLE cycle.
- `result` updates only on entry to RESPOND and is held otherwise.

## Configuration
- `INV_ARB_TIMEOUT_EN` defined:
  - An 8-bit watchdog counter increments on each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES without `inv_valid`, the block enters RESPOND with `result`=0, `done[grant_id]`=1 and `error[grant_id]`=1.
  - If `inv_valid` and timeout fall in the same cycle, `inv_valid` wins and `error` stays 0.
- `INV_ARB_TIMEOUT_EN` undefined: no counter is built, WAIT lasts indefinitely, and `error` is tied to 0.

## Test plan
- Reset release, `req`=4'b0001, `req_v`=(1.0,2.0,4.0), unit latency 3:
  - `inv_strobe` pulses 1 cycle after `req`.
  - `done`=4'b0001 appears 6 cycles after `req`, with `result`=(1.0,0.5,0.25).
- All four `req` held high continuously: grant order is 0,1,2,3,0, each client receiving exactly one `done` per rotation.
- `req`=4'b1010 after client 3 was last served: client 1 is granted first, then client 3.
- Client 2's `req_v` changed and `req` dropped during WAIT: `inv_v` stays unchanged and `done[2]` still pulses with the original result.
- `resetn` pulled low during WAIT, then `inv_valid` pulses after release:
  - No `done` pulse occurs and `busy`=0.
  - The next `req` from client 0 is granted normally.
- `INV_ARB_TIMEOUT_EN` defined, TIMEOUT_CYCLES=8, `inv_valid` never asserted:
  - `done` and `error` pulse together for the granted client 8 WAIT cycles after ISSUE, with `result`=0.
  - The arbiter then returns to IDLE.

Source files
------------

// File: rtl/inv_dir_arbiter_if.sv
// Client/unit handshake bundle for inv_dir_arbiter. Vectors are three packed
// Q(COMP_W) components {x, y, z}, x in the most significant slot.
interface inv_dir_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned COMP_W  = 32
);
  localparam int unsigned VEC_W = 3 * COMP_W;

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ-1:0][VEC_W-1:0] req_v;
  logic [NUM_REQ-1:0]            done;
  logic [NUM_REQ-1:0]            error;
  logic [VEC_W-1:0]              result;
  logic                          busy;
  logic                          inv_strobe;
  logic [VEC_W-1:0]              inv_v;
  logic                          inv_valid;
  logic [VEC_W-1:0]              inv_ov;

  // Arbiter side
  modport slave (
    input  req, req_v, inv_valid, inv_ov,
    output done, error, result, busy, inv_strobe, inv_v
  );

  // Clients plus inverse unit side
  modport master (
    output req, req_v, inv_valid, inv_ov,
    input  done, error, result, busy, inv_strobe, inv_v
  );
endinterface

// File: rtl/inv_dir_arbiter.sv
// Round-robin scheduler sharing one Fixed3 inverse-direction unit among NUM_REQ clients.
// Optional watchdog enabled by defining INV_ARB_TIMEOUT_EN.
module inv_dir_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned COMP_W         = 32
) (
  input logic              clk,
  input logic              resetn,
  inv_dir_arbiter_if.slave bus
);

  localparam int unsigned VEC_W = 3 * COMP_W;
  localparam int unsigned ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StRespond} state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   grant_q, grant_d;
  logic [ID_W-1:0]   last_grant_q, last_grant_d;
  logic [VEC_W-1:0]  inv_v_q, inv_v_d;
  logic [VEC_W-1:0]  result_q, result_d;
  logic [ID_W-1:0]   pick_id, scan_id;
  logic              pick_found;
  logic              strobe;
  logic              wdog_expire;
  logic [NUM_REQ-1:0] done_vec;

  // Rotating-priority search starting just above the last served client.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    scan_id    = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      scan_id = ID_W'((32'(last_grant_q) + i) % NUM_REQ);
      if (!pick_found && bus.req[scan_id]) begin
        pick_found = 1'b1;
        pick_id    = scan_id;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    inv_v_d      = inv_v_q;
    result_d     = result_q;
    strobe       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pick_found) begin
          grant_d = pick_id;
          inv_v_d = bus.req_v[pick_id];
          state_d = StIssue;
        end
      end
      StIssue: begin
        strobe  = 1'b1;
        state_d = StWait;
      end
      StWait: begin
        if (bus.inv_valid) begin
          result_d = bus.inv_ov;
          state_d  = StRespond;
        end else if (wdog_expire) begin
          result_d = '0;
          state_d  = StRespond;
        end
      end
      StRespond: begin
        last_grant_d = grant_q;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= StIdle;
      grant_q      <= '0;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      inv_v_q      <= '0;
      result_q     <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      inv_v_q      <= inv_v_d;
      result_q     <= result_d;
    end
  end

  always_comb begin
    done_vec = '0;
    if (state_q == StRespond) begin
      done_vec[grant_q] = 1'b1;
    end
  end

`ifdef INV_ARB_TIMEOUT_EN
  logic [7:0] wdog_q, wdog_d;
  logic       timed_out_q, timed_out_d;

  // Expires on the WAIT cycle in which the count would reach TIMEOUT_CYCLES.
  assign wdog_expire = (state_q == StWait) && (wdog_q == 8'(TIMEOUT_CYCLES - 1));

  always_comb begin
    wdog_d      = wdog_q;
    timed_out_d = timed_out_q;
    if (state_q == StIssue) begin
      wdog_d = '0;
    end else if (state_q == StWait) begin
      wdog_d = wdog_q + 8'd1;
    end
    // A coincident inv_valid takes precedence over the watchdog.
    if (wdog_expire && !bus.inv_valid) begin
      timed_out_d = 1'b1;
    end else if (state_q == StRespond) begin
      timed_out_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wdog_q      <= '0;
      timed_out_q <= 1'b0;
    end else begin
      wdog_q      <= wdog_d;
      timed_out_q <= timed_out_d;
    end
  end

  assign bus.error = done_vec & {NUM_REQ{timed_out_q}};
`else
  assign wdog_expire = 1'b0;
  assign bus.error   = '0;
`endif

  assign bus.done       = done_vec;
  assign bus.result     = result_q;
  assign bus.inv_v      = inv_v_q;
  assign bus.inv_strobe = strobe;
  assign bus.busy       = (state_q != StIdle);

  param_range_a: assert property (@(posedge clk)
    (NUM_REQ >= 2) && (NUM_REQ <= 8) && (TIMEOUT_CYCLES >= 2) && (TIMEOUT_CYCLES <= 255));

endmodule

// File: tb/tb_inv_dir_arbiter.sv
// Directed bench for inv_dir_arbiter: the bench plays the clients and the inverse unit.
module tb_inv_dir_arbiter;
  localparam int unsigned NREQ = 4;

  localparam logic [31:0] ONE   = 32'h0001_0000;
  localparam logic [31:0] TWO   = 32'h0002_0000;
  localparam logic [31:0] FOUR  = 32'h0004_0000;
  localparam logic [31:0] HALF  = 32'h0000_8000;
  localparam logic [31:0] QUART = 32'h0000_4000;

  localparam logic [95:0] V0 = {ONE, TWO, FOUR};
  localparam logic [95:0] R0 = {ONE, HALF, QUART};
  localparam logic [95:0] V1 = {TWO, TWO, TWO};
  localparam logic [95:0] R1 = {HALF, HALF, HALF};
  localparam logic [95:0] V2 = {FOUR, ONE, TWO};
  localparam logic [95:0] R2 = {QUART, ONE, HALF};
  localparam logic [95:0] V3 = {ONE, ONE, ONE};
  localparam logic [95:0] R3 = {ONE, ONE, ONE};
  localparam logic [95:0] VX = {FOUR, FOUR, FOUR};

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  inv_dir_arbiter_if #(.NUM_REQ(NREQ), .COMP_W(32)) bus ();

  inv_dir_arbiter #(.NUM_REQ(NREQ), .TIMEOUT_CYCLES(8), .COMP_W(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered in an IDLE cycle with req already driven; returns in the RESPOND cycle.
  // The unit raises inv_valid lat cycles after the strobe cycle.
  task automatic op(input int lat, input logic [95:0] vin, input logic [95:0] ov,
                    input logic [3:0] exp_done, input string tag);
    tick();
    check({tag, "_strobe"}, 128'(bus.inv_strobe), 128'(1));
    check({tag, "_inv_v"}, 128'(bus.inv_v), 128'(vin));
    tick();
    check({tag, "_strobe_low"}, 128'(bus.inv_strobe), 128'(0));
    repeat (lat - 1) tick();
    check({tag, "_no_early_done"}, 128'(bus.done), 128'(0));
    bus.inv_valid = 1'b1;
    bus.inv_ov    = ov;
    tick();
    bus.inv_valid = 1'b0;
    bus.inv_ov    = '0;
    check({tag, "_done"}, 128'(bus.done), 128'(exp_done));
    check({tag, "_error"}, 128'(bus.error), 128'(0));
    check({tag, "_result"}, 128'(bus.result), 128'(ov));
  endtask

  initial begin
    bus.req       = '0;
    bus.req_v     = '0;
    bus.inv_valid = 1'b0;
    bus.inv_ov    = '0;
    repeat (2) tick();
    check("rst_done", 128'(bus.done), 128'(0));
    check("rst_error", 128'(bus.error), 128'(0));
    check("rst_strobe", 128'(bus.inv_strobe), 128'(0));
    check("rst_busy", 128'(bus.busy), 128'(0));
    check("rst_result", 128'(bus.result), 128'(0));
    check("rst_inv_v", 128'(bus.inv_v), 128'(0));
    resetn = 1'b1;
    tick();

    // Single request, unit latency 3: strobe next cycle, done in the sixth cycle counting req.
    bus.req      = 4'b0001;
    bus.req_v[0] = V0;
    check("t1_idle_strobe", 128'(bus.inv_strobe), 128'(0));
    op(3, V0, R0, 4'b0001, "t1");
    bus.req = '0;
    tick();
    check("t1_idle_busy", 128'(bus.busy), 128'(0));
    check("t1_done_one_cycle", 128'(bus.done), 128'(0));
    check("t1_result_held", 128'(bus.result), 128'(R0));

    // Fresh reset so client 0 has top priority, then all four held: 0,1,2,3,0.
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    bus.req   = 4'b1111;
    bus.req_v = {V3, V2, V1, V0};
    op(2, V0, R0, 4'b0001, "rot0");
    tick();
    op(1, V1, R1, 4'b0010, "rot1");
    tick();
    op(4, V2, R2, 4'b0100, "rot2");
    tick();
    op(2, V3, R3, 4'b1000, "rot3");
    tick();
    op(1, V0, R0, 4'b0001, "rot4");

    // Serve client 3 alone, then 1010 must go 1 before 3.
    bus.req = 4'b1000;
    tick();
    op(1, V3, R3, 4'b1000, "c3");
    bus.req = 4'b1010;
    tick();
    op(2, V1, R1, 4'b0010, "rr_first");
    bus.req = 4'b1000;
    tick();
    op(2, V3, R3, 4'b1000, "rr_second");
    bus.req = '0;
    tick();

    // Client 2 changes req_v and drops req while its operation is in WAIT.
    bus.req      = 4'b0100;
    bus.req_v[2] = V2;
    tick();
    check("chg_inv_v_issue", 128'(bus.inv_v), 128'(V2));
    tick();
    bus.req_v[2] = VX;
    bus.req      = '0;
    tick();
    check("chg_inv_v_wait", 128'(bus.inv_v), 128'(V2));
    bus.inv_valid = 1'b1;
    bus.inv_ov    = R2;
    tick();
    bus.inv_valid = 1'b0;
    check("chg_done", 128'(bus.done), 128'(4'b0100));
    check("chg_result", 128'(bus.result), 128'(R2));
    tick();

    // Reset during WAIT, then a late inv_valid must be ignored.
    bus.req      = 4'b0001;
    bus.req_v[0] = V0;
    tick();
    tick();
    check("rw_busy_before", 128'(bus.busy), 128'(1));
    resetn  = 1'b0;
    bus.req = '0;
    #2;
    check("rw_busy_in_reset", 128'(bus.busy), 128'(0));
    check("rw_inv_v_in_reset", 128'(bus.inv_v), 128'(0));
    tick();
    resetn = 1'b1;
    tick();
    bus.inv_valid = 1'b1;
    bus.inv_ov    = R0;
    tick();
    bus.inv_valid = 1'b0;
    check("rw_late_done", 128'(bus.done), 128'(0));
    check("rw_late_busy", 128'(bus.busy), 128'(0));
    check("rw_late_result", 128'(bus.result), 128'(0));
    tick();
    bus.req = 4'b0001;
    op(3, V0, R0, 4'b0001, "rw_next");
    bus.req = '0;
    tick();

`ifdef INV_ARB_TIMEOUT_EN
    // Unit never answers: done and error together after 8 WAIT cycles.
    bus.req      = 4'b0010;
    bus.req_v[1] = V1;
    tick();
    check("to_strobe", 128'(bus.inv_strobe), 128'(1));
    repeat (8) tick();
    check("to_no_done_wait8", 128'(bus.done), 128'(0));
    check("to_busy_wait8", 128'(bus.busy), 128'(1));
    tick();
    check("to_done", 128'(bus.done), 128'(4'b0010));
    check("to_error", 128'(bus.error), 128'(4'b0010));
    check("to_result", 128'(bus.result), 128'(0));
    bus.req = '0;
    tick();
    check("to_idle_busy", 128'(bus.busy), 128'(0));
    check("to_error_clear", 128'(bus.error), 128'(0));

    // inv_valid on the expiring cycle wins.
    bus.req      = 4'b0100;
    bus.req_v[2] = V2;
    tick();
    repeat (8) tick();
    bus.inv_valid = 1'b1;
    bus.inv_ov    = R2;
    tick();
    bus.inv_valid = 1'b0;
    check("tie_done", 128'(bus.done), 128'(4'b0100));
    check("tie_error", 128'(bus.error), 128'(0));
    check("tie_result", 128'(bus.result), 128'(R2));
    bus.req = '0;
    tick();
`else
    // Without the watchdog WAIT holds until the unit answers.
    bus.req      = 4'b0010;
    bus.req_v[1] = V1;
    tick();
    repeat (20) tick();
    check("nowd_busy", 128'(bus.busy), 128'(1));
    check("nowd_no_done", 128'(bus.done), 128'(0));
    bus.inv_valid = 1'b1;
    bus.inv_ov    = R1;
    tick();
    bus.inv_valid = 1'b0;
    check("nowd_done", 128'(bus.done), 128'(4'b0010));
    check("nowd_error", 128'(bus.error), 128'(0));
    check("nowd_result", 128'(bus.result), 128'(R1));
    bus.req = '0;
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
